// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_port_arbiter_pkg                                              |
// | Purpose: Shared constants and state/owner encodings for the instruction/   |
// |          data RAM port arbiter.                                            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam logic        c_RST_ENABLE   = 1'b1;
  localparam logic        c_CHIP_ENABLE  = 1'b1;
  localparam logic        c_CHIP_DISABLE = 1'b0;
  localparam logic [31:0] c_ZERO_WORD    = 32'h0000_0000;
  localparam logic [3:0]  c_SEL_ALL      = 4'b1111;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  // Which pipeline port currently owns the RAM
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_port_arbiter_if                                               |
// | Purpose: Bundles the inst port, data port, RAM command port and stall      |
// |          requests around the shared RAM arbiter.                           |
// | Ports  : slave  - arbiter side (takes requests, drives acks/RAM/stalls)    |
// |          master - pipeline + RAM side (drives requests and RAM read data)  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if;

  // Instruction fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  // Data load/store port
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  // Single-port synchronous RAM
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Stall requests toward the pipeline control unit
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_sel, d_addr, d_wdata,
    input  mem_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_sel, d_addr, d_wdata,
    output mem_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_port_arbiter                                                  |
// | Purpose: Shares one fixed-latency single-port RAM between the IF stage     |
// |          (inst port) and the MEM stage (data port). One access at a time:  |
// |          IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP. Data port wins    |
// |          ties; after STARVE_LIM consecutive data grants with a fetch       |
// |          pending, the fetch is forced through.                             |
// | Ports  : clk, rst (sync, active high)                                      |
// |          bus : mem_port_arbiter_if.slave (inst/data ports, RAM, stalls)    |
// | Params : MEM_LAT    RAM read latency after mem_ce is sampled (1..7)        |
// |          STARVE_LIM max data grants in a row while a fetch waits (>=1)     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int                    c_STREAK_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_LIM = c_STREAK_W'(STARVE_LIM);
  localparam logic [2:0]            c_LAT_LOAD   = 3'(MEM_LAT - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  owner_t                r_owner;
  logic [2:0]            r_lat_cnt;
  logic [c_STREAK_W-1:0] r_streak;

  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_i_rdata;
  logic [31:0]           r_d_rdata;

  logic                  w_starve;
  logic                  w_grant_data;
  logic                  w_grant_inst;
  logic                  w_wait_last;
  logic                  w_mem_ce;
  logic                  w_mem_we;
  logic                  w_i_ack;
  logic                  w_d_ack;

  // Grant decision, only acted on in IDLE. The fetch is forced once the data
  // port has won STARVE_LIM times in a row while the fetch was waiting.
  assign w_starve     = bus.i_req && (r_streak == c_STREAK_LIM);
  assign w_grant_data = bus.d_req && !w_starve;
  assign w_grant_inst = !w_grant_data && bus.i_req;
  assign w_wait_last  = (r_lat_cnt == 3'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_mem_ce    = c_CHIP_DISABLE;
    w_mem_we    = 1'b0;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_data || w_grant_inst) begin
          w_state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        w_mem_ce    = c_CHIP_ENABLE;
        w_mem_we    = r_we;          // r_we is only ever set for a data-port store
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (w_wait_last) begin
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        w_i_ack     = (r_owner == OWN_INST);
        w_d_ack     = (r_owner == OWN_DATA);
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Command capture, latency countdown, read-data capture and streak tracking
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE) begin
      r_owner   <= OWN_INST;
      r_lat_cnt <= 3'd0;
      r_streak  <= '0;
      r_we      <= 1'b0;
      r_sel     <= 4'b0000;
      r_addr    <= c_ZERO_WORD;
      r_wdata   <= c_ZERO_WORD;
      r_i_rdata <= c_ZERO_WORD;
      r_d_rdata <= c_ZERO_WORD;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          // Streak only grows while a fetch is actually being held off
          if (!bus.i_req) begin
            r_streak <= '0;
          end else if (w_grant_data) begin
            if (r_streak != c_STREAK_LIM) begin
              r_streak <= r_streak + c_STREAK_W'(1);
            end
          end else begin
            r_streak <= '0;
          end

          if (w_grant_data) begin
            r_owner <= OWN_DATA;
            r_addr  <= bus.d_addr;
            r_we    <= bus.d_we;
            r_sel   <= bus.d_we ? bus.d_sel : c_SEL_ALL;
            r_wdata <= bus.d_we ? bus.d_wdata : c_ZERO_WORD;
          end else if (w_grant_inst) begin
            r_owner <= OWN_INST;
            r_addr  <= bus.i_addr;
            r_we    <= 1'b0;
            r_sel   <= c_SEL_ALL;
            r_wdata <= c_ZERO_WORD;
          end
        end
        ARB_ISSUE: begin
          r_lat_cnt <= c_LAT_LOAD;
        end
        ARB_WAIT: begin
          if (!w_wait_last) begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end else if (r_owner == OWN_DATA) begin
            // A store returns zero rather than whatever the RAM drives
            r_d_rdata <= r_we ? c_ZERO_WORD : bus.mem_rdata;
          end else begin
            r_i_rdata <= bus.mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_ce    = w_mem_ce;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_sel   = r_sel;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.i_ack     = w_i_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;

  assign bus.stall_if  = bus.i_req & ~w_i_ack;
  assign bus.stall_mem = bus.d_req & ~w_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mem_port_arbiter                                               |
// | Purpose: Directed self-checking bench for mem_port_arbiter with a          |
// |          1-cycle-latency RAM model and an ordered ack scoreboard.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LAT    (1),
    .STARVE_LIM (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, byte-enabled writes
  logic [31:0] ram [0:255];
  logic [31:0] r_ram_q = 32'h0;
  assign bus.mem_rdata = r_ram_q;

  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_sel[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        r_ram_q <= ram[bus.mem_addr[9:2]];
      end
    end
  end

  // Scoreboard of expected acks, in the order they must occur
  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t q_exp[$];

  task automatic push_exp(input bit is_data, input logic [31:0] rdata, input int c);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    e.cyc     = c;
    q_exp.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ack monitor and protocol invariants
  logic prev_ce = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ce = 1'b0;
    end else begin
      chk("ack_exclusive", 32'(bus.i_ack & bus.d_ack), 32'd0);
      chk("ce_not_back_to_back", 32'(bus.mem_ce & prev_ce), 32'd0);
      prev_ce = bus.mem_ce;
      if (bus.i_ack || bus.d_ack) begin
        if (q_exp.size() == 0) begin
          chk("spurious_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("ack_port", 32'(bus.d_ack), 32'(e.is_data));
          chk("ack_rdata", e.is_data ? bus.d_rdata : bus.i_rdata, e.rdata);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  int t0;

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 32'h0;
    ram[8'h04] = 32'h3C01_1234;   // byte address 0x10
    ram[8'h08] = 32'h1122_3344;   // byte address 0x20

    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_sel   = 4'h0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_i_ack",     32'(bus.i_ack),  32'd0);
    chk("rst_d_ack",     32'(bus.d_ack),  32'd0);
    chk("rst_mem_ce",    32'(bus.mem_ce), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst_mem_sel",   32'(bus.mem_sel), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_i_rdata",   bus.i_rdata,   32'd0);
    chk("rst_d_rdata",   bus.d_rdata,   32'd0);
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_ce",    32'(bus.mem_ce),    32'd0);
    chk("idle_stall_if",  32'(bus.stall_if),  32'd0);
    chk("idle_stall_mem", 32'(bus.stall_mem), 32'd0);

    // Single instruction fetch
    tick(1);
    t0 = cyc;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    push_exp(1'b0, 32'h3C01_1234, t0 + 3);
    @(negedge clk);
    chk("f_c0_stall_if",  32'(bus.stall_if),  32'd1);
    chk("f_c0_stall_mem", 32'(bus.stall_mem), 32'd0);
    chk("f_c0_mem_ce",    32'(bus.mem_ce),    32'd0);
    tick(1);
    @(negedge clk);
    chk("f_c1_mem_ce",   32'(bus.mem_ce),  32'd1);
    chk("f_c1_mem_we",   32'(bus.mem_we),  32'd0);
    chk("f_c1_mem_addr", bus.mem_addr,     32'h10);
    chk("f_c1_mem_sel",  32'(bus.mem_sel), 32'hF);
    chk("f_c1_stall_if", 32'(bus.stall_if), 32'd1);
    tick(1);
    @(negedge clk);
    chk("f_c2_mem_ce",   32'(bus.mem_ce),   32'd0);
    chk("f_c2_stall_if", 32'(bus.stall_if), 32'd1);
    tick(1);
    @(negedge clk);
    chk("f_c3_i_ack",    32'(bus.i_ack),    32'd1);
    chk("f_c3_stall_if", 32'(bus.stall_if), 32'd0);
    tick(1);
    bus.i_req = 1'b0;

    // Simultaneous fetch and load: data first, fetch next
    tick(1);
    t0 = cyc;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    push_exp(1'b1, 32'h1122_3344, t0 + 3);
    push_exp(1'b0, 32'h3C01_1234, t0 + 7);
    tick(1);
    @(negedge clk);
    chk("both_c1_mem_addr", bus.mem_addr, 32'h20);
    tick(3);
    bus.d_req = 1'b0;
    tick(4);
    bus.i_req = 1'b0;

    // Partial store, then load back
    tick(1);
    t0 = cyc;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_sel   = 4'b0011;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'hAABB_CCDD;
    push_exp(1'b1, 32'h0, t0 + 3);
    @(negedge clk);
    chk("st_c0_stall_mem", 32'(bus.stall_mem), 32'd1);
    tick(1);
    @(negedge clk);
    chk("st_c1_mem_ce",    32'(bus.mem_ce),  32'd1);
    chk("st_c1_mem_we",    32'(bus.mem_we),  32'd1);
    chk("st_c1_mem_sel",   32'(bus.mem_sel), 32'h3);
    chk("st_c1_mem_wdata", bus.mem_wdata,    32'hAABB_CCDD);
    tick(3);
    bus.d_we    = 1'b0;
    bus.d_sel   = 4'h0;
    bus.d_wdata = 32'h0;
    push_exp(1'b1, 32'h1122_CCDD, t0 + 7);
    tick(1);
    @(negedge clk);
    chk("ld_c1_mem_we",  32'(bus.mem_we),  32'd0);
    chk("ld_c1_mem_sel", 32'(bus.mem_sel), 32'hF);
    tick(3);
    bus.d_req = 1'b0;

    // Continuous contention: 4 data grants then 1 fetch, twice
    tick(1);
    t0 = cyc;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push_exp(1'b0, 32'h3C01_1234, t0 + 4*k + 3);
      else            push_exp(1'b1, 32'h1122_CCDD, t0 + 4*k + 3);
    end
    tick(40);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick(2);

    // Reset during WAIT: no ack, then a fresh fetch completes
    t0 = cyc;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    tick(2);
    rst       = 1'b1;
    bus.i_req = 1'b0;
    tick(1);
    @(negedge clk);
    chk("rst_wait_i_ack",   32'(bus.i_ack),  32'd0);
    chk("rst_wait_mem_ce",  32'(bus.mem_ce), 32'd0);
    chk("rst_wait_i_rdata", bus.i_rdata,     32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    t0 = cyc;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    push_exp(1'b0, 32'h3C01_1234, t0 + 3);
    tick(4);
    bus.i_req = 1'b0;
    tick(2);

    @(negedge clk);
    chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
